memtest_sequencer: RTL and testbench
====================================

// Module: memtest_sequencer
// PURPOSE
//  Self-test sequencer upstream of the SDRAM AXI memif. Fires write_start_triger, then read_start_triger.
//  Passively snoops the B and R channels between the AXI master controls and the SDRAM subsystem.
//  Checks each read beat against the incrementing pattern the write control produces.
//  Reports pass/fail, error counts and completed-pass count; optional free-running loop for soak tests.
// PARAMETERS
//  BURST_LEN    256       beats per burst; equals awlen/arlen+1 of the master controls (1..256)
//  PAT_SEED     16'h0000  expected data of beat 0
//  TIMEOUT_CYC  4096      max cycles in any wait state before timeout error (>=2)
//  LOOP_GAP     16        idle cycles between passes when loop_en=1
// PORTS
//  clk                 in   1   system clock (ref_clk domain, 100MHz)
//  reset_n             in   1   async active-low reset
//  start               in   1   begin one test pass (sampled in IDLE only)
//  loop_en             in   1   1: restart automatically after a passing run
//  write_start_triger  out  1   1-cycle pulse to axim_write_control.start_triger
//  read_start_triger   out  1   1-cycle pulse to axim_read_control.start_triger
//  axi_bvalid_in       in   1   snooped B channel valid
//  axi_bready_in       in   1   snooped B channel ready
//  axi_bresp_in        in   2   snooped write response
//  axi_rvalid_in       in   1   snooped R channel valid
//  axi_rready_in       in   1   snooped R channel ready
//  axi_rdata_in        in   16  snooped read data
//  axi_rlast_in        in   1   snooped read last
//  busy                out  1   high from leaving IDLE until DONE/FAIL
//  pass                out  1   sticky: last run completed with zero errors
//  fail                out  1   sticky: last run had an error/timeout; cleared by next start
//  err_count           out  16  mismatching beats in current run, saturates at 16'hFFFF
//  first_err_beat      out  8   beat index of first mismatch (valid when err_count!=0)
//  fail_code           out  3   0 none, 1 data, 2 bresp!=OKAY, 3 early rlast, 4 missing rlast, 5 timeout
//  pass_count          out  16  completed passing runs since reset, wraps
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. Asserting reset_n low mid-run aborts immediately.
//  Beat: counted only on rvalid&rready. B accepted only on bvalid&bready. Sequencer never drives AXI.
//  FSM:
//   - IDLE: start=1 (or loop restart) -> WR_TRIG; clear pass, fail, err_count, fail_code, first_err_beat.
//   - WR_TRIG: write_start_triger=1 for exactly one cycle -> WR_WAIT; timer cleared.
//   - WR_WAIT: on B handshake, bresp!=0 -> FAIL code 2; else -> RD_TRIG.
//   - RD_TRIG: read_start_triger=1 for one cycle -> RD_WAIT; beat index cleared.
//   - RD_WAIT, each beat with index i:
//       - compare rdata to (PAT_SEED+i) mod 2^16.
//       - mismatch: err_count+=1 (saturating); on the first one, first_err_beat=i.
//       - rlast with i<BURST_LEN-1 -> FAIL code 3.
//       - i==BURST_LEN-1 without rlast -> FAIL code 4.
//       - rlast at i==BURST_LEN-1 -> DONE.
//   - DONE (1 cycle): err_count==0 -> pass=1, pass_count+=1; else fail=1, fail_code=1.
//       Then -> GAP if loop_en & pass, else IDLE.
//   - GAP: count LOOP_GAP cycles -> WR_TRIG. loop_en=0 during GAP -> IDLE.
//   - FAIL (1 cycle): fail=1 -> IDLE. No auto-restart.
//  Timeout: timer runs in WR_WAIT/RD_WAIT, cleared on each handshake; reaching TIMEOUT_CYC -> FAIL code 5.
//  Edge cases:
//   - start while busy is ignored; start held high restarts once per return to IDLE.
//   - Data error and length error on the same beat: length code wins, err_count still increments.
//   - busy=1 in every state except IDLE; pass/fail are held in IDLE.
//  Latency: trigger pulse 1 cycle after start; pass/fail set 1 cycle after the rlast beat.
// TESTING
//  1 BURST_LEN=4, start; B OKAY; R beats 0,1,2,3 with rlast on beat 3 -> pass=1, pass_count=1, err_count=0.
//  2 Same, beat 2 data=16'hBEEF -> fail=1, fail_code=1, err_count=1, first_err_beat=2.
//  3 bresp=2'b10 -> fail_code=2, read_start_triger never pulses.
//  4 rlast on beat 1 -> fail_code=3; in a second run, no rlast on beat 3 -> fail_code=4.
//  5 TIMEOUT_CYC=32, no bvalid -> fail_code=5 on cycle 32 of WR_WAIT; reset_n low mid-RD_WAIT -> all outputs 0.
//  6 loop_en=1, LOOP_GAP=16 -> next write_start_triger 17 cycles after DONE; 3 runs -> pass_count=3.

Source files
------------

// File: rtl/memtest_sequencer_if.sv
// Snooped AXI B and R channel signals observed by the memory self-test sequencer.
// The sequencer only listens; the master modport belongs to whatever drives these wires.
interface memtest_sequencer_if;
    logic        axi_bvalid_in;
    logic        axi_bready_in;
    logic [1:0]  axi_bresp_in;
    logic        axi_rvalid_in;
    logic        axi_rready_in;
    logic [15:0] axi_rdata_in;
    logic        axi_rlast_in;

    modport master (
        output axi_bvalid_in, axi_bready_in, axi_bresp_in,
        output axi_rvalid_in, axi_rready_in, axi_rdata_in, axi_rlast_in
    );

    modport slave (
        input axi_bvalid_in, axi_bready_in, axi_bresp_in,
        input axi_rvalid_in, axi_rready_in, axi_rdata_in, axi_rlast_in
    );
endinterface

// File: rtl/memtest_sequencer.sv
// Memory self-test sequencer: triggers a write burst then a read burst, snoops B/R
// handshakes and checks the read data against an incrementing pattern.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; pass/fail of the last run held
// S_WR_TRIG | one-cycle write_start_triger pulse
// S_WR_WAIT | waiting for the B handshake, timeout armed
// S_RD_TRIG | one-cycle read_start_triger pulse
// S_RD_WAIT | checking read beats, timeout armed
// S_DONE    | burst complete; resolve pass or data failure
// S_GAP     | idle spacing between looped runs
// S_FAIL    | protocol failure or timeout; raise fail
module memtest_sequencer #(
    parameter int          BURST_LEN   = 256,
    parameter logic [15:0] PAT_SEED    = 16'h0000,
    parameter int          TIMEOUT_CYC = 4096,
    parameter int          LOOP_GAP    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                loop_en,
    output logic                write_start_triger,
    output logic                read_start_triger,
    memtest_sequencer_if.slave  axi,
    output logic                busy,
    output logic                pass,
    output logic                fail,
    output logic [15:0]         err_count,
    output logic [7:0]          first_err_beat,
    output logic [2:0]          fail_code,
    output logic [15:0]         pass_count
);

    localparam int             TW         = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam int             GW         = (LOOP_GAP > 2) ? $clog2(LOOP_GAP) : 1;
    localparam logic [GW-1:0]  GAP_LOAD   = GW'((LOOP_GAP > 0) ? (LOOP_GAP - 1) : 0);
    localparam logic [7:0]     LAST_BEAT  = 8'(BURST_LEN - 1);

    localparam logic [2:0] CODE_DATA    = 3'd1;
    localparam logic [2:0] CODE_BRESP   = 3'd2;
    localparam logic [2:0] CODE_EARLY   = 3'd3;
    localparam logic [2:0] CODE_MISSING = 3'd4;
    localparam logic [2:0] CODE_TIMEOUT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_TRIG, S_WR_WAIT, S_RD_TRIG, S_RD_WAIT, S_DONE, S_GAP, S_FAIL
    } state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  timer;
    logic [GW-1:0]  gap_cnt;
    logic [7:0]     beat_idx;
    logic           b_hs, r_hs, beat_bad, at_last_beat;
    logic           run_start, code_we;
    logic [2:0]     code_nxt;

    assign b_hs         = axi.axi_bvalid_in & axi.axi_bready_in;
    assign r_hs         = axi.axi_rvalid_in & axi.axi_rready_in;
    assign at_last_beat = (beat_idx == LAST_BEAT);
    assign beat_bad     = (axi.axi_rdata_in != (PAT_SEED + 16'(beat_idx)));

    assign write_start_triger = (state == S_WR_TRIG);
    assign read_start_triger  = (state == S_RD_TRIG);
    assign busy               = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        code_we   = 1'b0;
        code_nxt  = 3'd0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WR_TRIG;
                    run_start = 1'b1;
                end
            end
            S_WR_TRIG: state_nxt = S_WR_WAIT;
            S_WR_WAIT: begin
                if (b_hs) begin
                    if (axi.axi_bresp_in != 2'b00) begin
                        state_nxt = S_FAIL;
                        code_we   = 1'b1;
                        code_nxt  = CODE_BRESP;
                    end else begin
                        state_nxt = S_RD_TRIG;
                    end
                end else if (timer == '0) begin
                    state_nxt = S_FAIL;
                    code_we   = 1'b1;
                    code_nxt  = CODE_TIMEOUT;
                end
            end
            S_RD_TRIG: state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                // Length violations take priority over a data mismatch on the same beat.
                if (r_hs) begin
                    if (axi.axi_rlast_in && !at_last_beat) begin
                        state_nxt = S_FAIL;
                        code_we   = 1'b1;
                        code_nxt  = CODE_EARLY;
                    end else if (!axi.axi_rlast_in && at_last_beat) begin
                        state_nxt = S_FAIL;
                        code_we   = 1'b1;
                        code_nxt  = CODE_MISSING;
                    end else if (axi.axi_rlast_in) begin
                        state_nxt = S_DONE;
                    end
                end else if (timer == '0) begin
                    state_nxt = S_FAIL;
                    code_we   = 1'b1;
                    code_nxt  = CODE_TIMEOUT;
                end
            end
            S_DONE: begin
                if (loop_en && (err_count == 16'd0)) state_nxt = S_GAP;
                else                                 state_nxt = S_IDLE;
            end
            S_GAP: begin
                if (!loop_en) begin
                    state_nxt = S_IDLE;
                end else if (gap_cnt == '0) begin
                    state_nxt = S_WR_TRIG;
                    run_start = 1'b1;
                end
            end
            S_FAIL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Timeout down-counter, reloaded on each handshake in the wait states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else begin
            case (state)
                S_WR_TRIG, S_RD_TRIG: timer <= TIMER_LOAD;
                S_WR_WAIT: timer <= b_hs ? TIMER_LOAD : ((timer != '0) ? timer - 1'b1 : timer);
                S_RD_WAIT: timer <= r_hs ? TIMER_LOAD : ((timer != '0) ? timer - 1'b1 : timer);
                default:   timer <= timer;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt  <= '0;
            beat_idx <= '0;
        end else begin
            if (state == S_DONE)                      gap_cnt <= GAP_LOAD;
            else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

            if (state == S_RD_TRIG)                 beat_idx <= '0;
            else if (state == S_RD_WAIT && r_hs)    beat_idx <= beat_idx + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass           <= 1'b0;
            fail           <= 1'b0;
            err_count      <= '0;
            first_err_beat <= '0;
            fail_code      <= '0;
            pass_count     <= '0;
        end else begin
            if (run_start) begin
                pass           <= 1'b0;
                fail           <= 1'b0;
                err_count      <= '0;
                first_err_beat <= '0;
                fail_code      <= '0;
            end
            if (state == S_RD_WAIT && r_hs && beat_bad) begin
                if (err_count == 16'd0)     first_err_beat <= beat_idx;
                if (err_count != 16'hFFFF)  err_count      <= err_count + 16'd1;
            end
            if (code_we) fail_code <= code_nxt;
            if (state == S_FAIL) fail <= 1'b1;
            if (state == S_DONE) begin
                if (err_count == 16'd0) begin
                    pass       <= 1'b1;
                    pass_count <= pass_count + 16'd1;
                end else begin
                    fail      <= 1'b1;
                    fail_code <= CODE_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_memtest_sequencer.sv
// Randomized scoreboard bench for memtest_sequencer: a run-level reference model pushes
// the expected outcome of each run; a monitor pops it whenever pass or fail rises.
module tb_memtest_sequencer;

    localparam int          BL   = 4;
    localparam logic [15:0] SEED = 16'hFFFE;
    localparam int          TO   = 32;
    localparam int          GAP  = 16;

    localparam int K_PASS = 0, K_DATA = 1, K_BRESP = 2, K_EARLY = 3,
                   K_MISSING = 4, K_WTO = 5, K_RTO = 6;

    typedef struct packed {
        logic        pass;
        logic        fail;
        logic [2:0]  code;
        logic [15:0] errs;
        logic [7:0]  first;
        logic [15:0] pcount;
        logic        rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        loop_en = 1'b0;
    logic        write_start_triger, read_start_triger;
    logic        busy, pass, fail;
    logic [15:0] err_count, pass_count;
    logic [7:0]  first_err_beat;
    logic [2:0]  fail_code;

    memtest_sequencer_if snoop ();

    memtest_sequencer #(
        .BURST_LEN(BL), .PAT_SEED(SEED), .TIMEOUT_CYC(TO), .LOOP_GAP(GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .loop_en(loop_en),
        .write_start_triger(write_start_triger), .read_start_triger(read_start_triger),
        .axi(snoop.slave),
        .busy(busy), .pass(pass), .fail(fail), .err_count(err_count),
        .first_err_beat(first_err_beat), .fail_code(fail_code), .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   exp_pass_count = 0;

    // current run descriptor
    logic        d_no_b;
    logic [1:0]  d_bresp;
    int          d_n;
    logic [15:0] d_data [BL];
    logic        d_last [BL];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        snoop.axi_bvalid_in = 1'b0; snoop.axi_bready_in = 1'b0; snoop.axi_bresp_in = 2'b00;
        snoop.axi_rvalid_in = 1'b0; snoop.axi_rready_in = 1'b0;
        snoop.axi_rdata_in  = 16'h0000; snoop.axi_rlast_in = 1'b0;
    endtask

    task automatic gen(input int kind);
        int j;
        d_no_b  = 1'b0;
        d_bresp = 2'b00;
        d_n     = BL;
        for (int k = 0; k < BL; k++) begin
            d_data[k] = SEED + 16'(k);
            d_last[k] = (k == BL - 1);
        end
        case (kind)
            K_DATA:
                for (int k = 0; k < BL; k++)
                    if ($urandom_range(0, 1) == 1) d_data[k] = d_data[k] ^ 16'($urandom_range(1, 65535));
            K_BRESP: d_bresp = 2'($urandom_range(1, 3));
            K_EARLY: begin
                j = $urandom_range(0, BL - 2);
                d_n = j + 1;
                d_last[j] = 1'b1;
                if ($urandom_range(0, 1) == 1) d_data[j] = d_data[j] ^ 16'h00F0;
            end
            K_MISSING: begin
                d_last[BL-1] = 1'b0;
                if ($urandom_range(0, 1) == 1) d_data[BL-1] = d_data[BL-1] ^ 16'h0101;
            end
            K_WTO: d_no_b = 1'b1;
            K_RTO: begin
                d_n = $urandom_range(0, BL - 1);
                d_last[BL-1] = 1'b0;
            end
            default: ;
        endcase
    endtask

    // Reference model: walk the run descriptor beat by beat and decide the outcome.
    task automatic model_push;
        exp_t e;
        bit   ended;
        e = '0;
        ended = 1'b0;
        if (d_no_b) begin
            e.fail = 1'b1; e.code = 3'd5;
        end else if (d_bresp != 2'b00) begin
            e.fail = 1'b1; e.code = 3'd2;
        end else begin
            e.rd = 1'b1;
            for (int k = 0; k < d_n; k++) begin
                if (d_data[k] != SEED + 16'(k)) begin
                    if (e.errs == 16'd0) e.first = 8'(k);
                    if (e.errs != 16'hFFFF) e.errs = e.errs + 16'd1;
                end
                if (d_last[k] && k < BL - 1) begin
                    e.fail = 1'b1; e.code = 3'd3; ended = 1'b1;
                    break;
                end
                if (k == BL - 1) begin
                    ended = 1'b1;
                    if (!d_last[k]) begin
                        e.fail = 1'b1; e.code = 3'd4;
                    end else if (e.errs == 16'd0) begin
                        e.pass = 1'b1;
                        exp_pass_count++;
                    end else begin
                        e.fail = 1'b1; e.code = 3'd1;
                    end
                    break;
                end
            end
            if (!ended) begin
                e.fail = 1'b1; e.code = 3'd5;
            end
        end
        e.pcount = 16'(exp_pass_count);
        exp_q.push_back(e);
    endtask

    task automatic measure_to(input string name);
        int cnt = 0;
        while (busy && cnt < 100) begin
            step;
            cnt++;
        end
        chk(name, 32'(cnt), 32'd34);
    endtask

    task automatic wait_idle;
        int cnt = 0;
        while (busy && cnt < 200) begin
            step;
            cnt++;
        end
        chk("run_ends", 32'(busy), 32'd0);
    endtask

    task automatic do_start;
        start = 1'b1;
        step;
        chk("wr_trig_latency", 32'(write_start_triger), 32'd1);
        start = 1'b0;
    endtask

    // Entered on the WR_TRIG sample.
    task automatic serve_b;
        int dly;
        if (d_no_b) begin
            measure_to("wr_timeout_cycles");
            return;
        end
        step;
        dly = $urandom_range(0, 4);
        for (int i = 0; i < dly; i++) begin
            snoop.axi_bvalid_in = 1'($urandom_range(0, 1));
            snoop.axi_bready_in = 1'b0;
            snoop.axi_bresp_in  = 2'b10;
            start = 1'($urandom_range(0, 1));
            step;
        end
        start = 1'b0;
        snoop.axi_bvalid_in = 1'b1;
        snoop.axi_bready_in = 1'b1;
        snoop.axi_bresp_in  = d_bresp;
        step;
        bus_idle;
    endtask

    // Entered on the sample just after the B handshake; returns on the sample after the last beat.
    task automatic serve_r;
        chk("rd_trig_latency", 32'(read_start_triger), 32'd1);
        if (d_n == 0) begin
            measure_to("rd_timeout_cycles");
            return;
        end
        step;
        for (int k = 0; k < d_n; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                snoop.axi_rvalid_in = 1'($urandom_range(0, 1));
                snoop.axi_rready_in = ~snoop.axi_rvalid_in;
                snoop.axi_rdata_in  = ~(SEED + 16'(k));
                snoop.axi_rlast_in  = 1'b1;
                step;
            end
            snoop.axi_rvalid_in = 1'b1;
            snoop.axi_rready_in = 1'b1;
            snoop.axi_rdata_in  = d_data[k];
            snoop.axi_rlast_in  = d_last[k];
            step;
        end
        bus_idle;
    endtask

    task automatic execute;
        model_push;
        do_start;
        serve_b;
        if (!d_no_b && d_bresp == 2'b00) serve_r;
        wait_idle;
        step;
        step;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_pass"},   32'(pass), 32'd0);
        chk({tag, "_fail"},   32'(fail), 32'd0);
        chk({tag, "_errcnt"}, 32'(err_count), 32'd0);
        chk({tag, "_first"},  32'(first_err_beat), 32'd0);
        chk({tag, "_code"},   32'(fail_code), 32'd0);
        chk({tag, "_pcount"}, 32'(pass_count), 32'd0);
        chk({tag, "_trigs"},  32'({write_start_triger, read_start_triger}), 32'd0);
    endtask

    // Monitor: compare each completed run against the oldest expected outcome.
    int   wr_cnt = 0, rd_cnt = 0;
    logic prev_done = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset_n) begin
            wr_cnt = 0; rd_cnt = 0; prev_done = 1'b0;
        end else begin
            if (write_start_triger) wr_cnt++;
            if (read_start_triger)  rd_cnt++;
            if ((pass | fail) && !prev_done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_completion: pass=%0d fail=%0d, expected no run", pass, fail);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pass",       32'(pass),       32'(mon_e.pass));
                    chk("fail",       32'(fail),       32'(mon_e.fail));
                    chk("fail_code",  32'(fail_code),  32'(mon_e.code));
                    chk("err_count",  32'(err_count),  32'(mon_e.errs));
                    if (mon_e.errs != 16'd0)
                        chk("first_err_beat", 32'(first_err_beat), 32'(mon_e.first));
                    chk("pass_count", 32'(pass_count), 32'(mon_e.pcount));
                    chk("wr_trig_count", 32'(wr_cnt), 32'd1);
                    chk("rd_trig_count", 32'(rd_cnt), 32'(mon_e.rd));
                end
                wr_cnt = 0; rd_cnt = 0;
            end
            prev_done = pass | fail;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus_idle;
        repeat (3) step;
        chk_zero("reset");
        reset_n = 1'b1;
        step;

        // directed runs
        gen(K_PASS); execute;
        gen(K_PASS); d_data[2] = 16'hBEEF; execute;
        gen(K_BRESP); d_bresp = 2'b10; execute;
        gen(K_PASS); d_last[1] = 1'b1; d_n = 2; execute;
        gen(K_MISSING); execute;
        gen(K_WTO); execute;
        gen(K_RTO); d_n = 0; execute;

        // reset in the middle of RD_WAIT
        gen(K_PASS);
        d_data[1] = 16'h1234;
        do_start;
        serve_b;
        chk("rst_run_rd_trig", 32'(read_start_triger), 32'd1);
        step;
        for (int k = 0; k < 2; k++) begin
            snoop.axi_rvalid_in = 1'b1; snoop.axi_rready_in = 1'b1;
            snoop.axi_rdata_in = d_data[k]; snoop.axi_rlast_in = 1'b0;
            step;
        end
        bus_idle;
        chk("pre_rst_errcnt", 32'(err_count), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_zero("midrun_reset");
        exp_pass_count = 0;
        step;
        reset_n = 1'b1;
        step;

        // free-running loop: three passing runs separated by the gap
        loop_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            gen(K_PASS);
            if (r == 0) begin
                model_push;
                do_start;
            end else begin
                cnt = 0;
                while (!write_start_triger && cnt < 60) begin
                    step;
                    cnt++;
                end
                chk("loop_gap_cycles", 32'(cnt), 32'd17);
                model_push;
            end
            serve_b;
            if (r == 2) loop_en = 1'b0;
            serve_r;
        end
        wait_idle;
        chk("loop_pass_count", 32'(pass_count), 32'd3);
        step;

        // randomized runs
        for (int i = 0; i < 24; i++) begin
            gen($urandom_range(0, 6));
            execute;
        end

        repeat (4) step;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
